instruction_fetch_decode: RTL

INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

---
 rtl/instruction_fetch_decode.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_decode.sv
// Single-instruction fetch/decode stage: PC drives a synchronous ROM, the fetched
// byte is latched into IR and decoded into one-hot flags. Build with IFD_BREAKPOINT_EN for breakpoint/halt support.
module instruction_fetch_decode (
  input  logic       clk,
  input  logic       reset,
  input  logic       increment_pc,
  input  logic       commit_branch,
  output logic [7:0] instr_addr,
  input  logic [7:0] instr_data,
  output logic       instr_valid,
  output logic       br,
  output logic       brz,
  output logic       addi,
  output logic       subi,
  output logic       sr0,
  output logic       srh0,
  output logic       clr,
  output logic       mov,
  output logic       mova,
  output logic       movr,
  output logic       movrhs,
  output logic       pause,
  output logic [1:0] dst,
  output logic [1:0] src,
  output logic [2:0] imm3,
  output logic [3:0] imm4,
`ifdef IFD_BREAKPOINT_EN
  input  logic [7:0] bp_addr,
  input  logic       bp_enable,
  input  logic       resume,
  output logic       halted,
`endif
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_CAPTURE = 2'd1,
    S_VALID   = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  pc;
  logic [7:0]  ir;
  logic [11:0] flags_q;
  logic [7:0]  branch_off;

  // Flag bit order, MSB first: br brz addi subi sr0 srh0 clr mov mova movr movrhs pause
  function automatic logic [11:0] decode(input logic [7:0] op);
    logic [11:0] f;
    f = '0;
    case (op[7:5])
      3'b000: f[11] = 1'b1;
      3'b001: f[10] = 1'b1;
      3'b010: f[9]  = 1'b1;
      3'b011: f[8]  = 1'b1;
      3'b100: if (op[4]) f[6] = 1'b1; else f[7] = 1'b1;
      3'b101: f[5]  = 1'b1;
      3'b110: f[4]  = 1'b1;
      default: begin
        case (op[4:3])
          2'b00:   f[3] = 1'b1;
          2'b01:   f[2] = 1'b1;
          2'b10:   f[1] = 1'b1;
          default: f[0] = 1'b1;
        endcase
      end
    endcase
    return f;
  endfunction

  assign branch_off = {{3{ir[4]}}, ir[4:0]};

  // Handshake: the control FSM may pulse increment_pc/commit_branch only while
  // instr_valid=1; that edge consumes the instruction. Pulses at other times are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= 8'h00;
      ir      <= 8'h00;
      flags_q <= '0;
      state   <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          ir <= instr_data;
`ifdef IFD_BREAKPOINT_EN
          if (bp_enable && (pc == bp_addr)) begin
            state <= S_HALT;
          end else begin
            flags_q <= decode(instr_data);
            state   <= S_VALID;
          end
`else
          flags_q <= decode(instr_data);
          state   <= S_VALID;
`endif
        end
        S_VALID: begin
          if (commit_branch) begin
            pc      <= pc + branch_off;
            flags_q <= '0;
            state   <= S_FETCH;
          end else if (increment_pc) begin
            pc      <= pc + 8'd1;
            flags_q <= '0;
            state   <= S_FETCH;
          end
        end
`ifdef IFD_BREAKPOINT_EN
        S_HALT: begin
          // IR was captured on the way in; resuming just republishes it.
          if (resume) begin
            flags_q <= decode(ir);
            state   <= S_VALID;
          end
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  assign instr_addr  = pc;
  assign instr_valid = (state == S_VALID);
  assign state_dbg   = state;
`ifdef IFD_BREAKPOINT_EN
  assign halted      = (state == S_HALT);
`endif

  assign {br, brz, addi, subi, sr0, srh0, clr, mov, mova, movr, movrhs, pause} = flags_q;
  assign dst  = ir[4:3];
  assign src  = ir[2:1];
  assign imm3 = ir[2:0];
  assign imm4 = ir[3:0];

endmodule
